hopfield_control_seq: RTL and testbench
=======================================

# hopfield_control_seq

Parametrised next-generation control FSM for the Hopfield network datapath. It sequences input capture, neuron updating, weight learning and completion. Over the first-generation controller it adds:
- an input-stability qualifier;
- a sequential (one-neuron-per-cycle) update mode with a neuron index output;
- a bounded learning phase, a done state and an optional sweep-limit timeout.

It sits between the pattern-input logic and the neuron/weight datapath, driving their modify strobes.

## Interface
- NUM_NEURONS, 16: neurons in the network; must be ≥ 2.
- STABLE_CYCLES, 2: consecutive `same_input` cycles required before leaving INPUT; must be ≥ 1.
- LEARN_CYCLES, 4: cycles `modify_weights` is held in LEARNING; must be ≥ 1.
- MAX_SWEEPS, 32: update sweeps allowed before timeout (only with the macro); must be ≥ 1.
- IDX_W, $clog2(NUM_NEURONS): width of `neuron_idx`.
- clk  input  1  clock; one clock domain.
- rst  input  1  reset, synchronous and active-high.
- same_input  input  1  input pattern equals previous cycle's pattern.
- converged  input  1  no neuron changed state over the last full sweep (sync mode: last cycle).
- update_mode  input  1  0 = synchronous (all neurons each cycle), 1 = sequential; sampled on INPUT→UPDATING.
- learn_enable  input  1  1 = learn after convergence, 0 = go straight to DONE; sampled at convergence.
- modify_neuron  output  1  neuron state write strobe.
- modify_neuron_using_input  output  1  neuron write takes the input pattern; only with `modify_neuron`.
- modify_weights  output  1  weight update strobe.
- neuron_idx  output  IDX_W  neuron being updated in sequential mode; 0 otherwise.
- seq_active  output  1  1 while UPDATING in sequential mode (datapath honours `neuron_idx`).
- state  output  3  current state encoding, for debug.
- done  output  1  high in DONE.
- timeout  output  1  high in FAIL; tied 0 without the macro.

## Operation
- States (3-bit): INPUT=0, UPDATING=1, LEARNING=2, DONE=3, FAIL=4.
- Outputs are Moore: combinational from registered state and counters only.

INPUT
- Outputs: `modify_neuron`=1, `modify_neuron_using_input`=1.
- `stable_cnt` increments while `same_input`=1 and clears when `same_input`=0.
- Exits to UPDATING when `same_input`=1 and `stable_cnt`=STABLE_CYCLES-1.
- On exit, latch `update_mode` into `mode_q`; clear `neuron_idx` and `sweep_cnt`.

UPDATING
- Outputs: `modify_neuron`=1, `modify_neuron_using_input`=0.
- Sequential mode: `neuron_idx` advances each cycle and wraps from NUM_NEURONS-1 to 0. Sweep end is the cycle with `neuron_idx`=NUM_NEURONS-1.
- Synchronous mode: every cycle is a sweep end.
- Transition priority:
  1. `same_input`=0 → INPUT.
  2. At sweep end with `converged`=1: `learn_enable`=1 → LEARNING, else → DONE.
  3. At sweep end otherwise: `sweep_cnt`++.
- `converged` is ignored outside a sweep end.

LEARNING
- Output: `modify_weights`=1 for exactly LEARN_CYCLES cycles (`learn_cnt` 0..LEARN_CYCLES-1), then → DONE.
- `same_input`=0 aborts immediately → INPUT; weights already written are kept.

DONE and FAIL
- No strobes asserted. Both hold until `same_input`=0, then → INPUT.

Reset
- state=INPUT; all counters, `neuron_idx` and `mode_q` = 0.
- Output values after reset: `modify_neuron`=1, `modify_neuron_using_input`=1, all other outputs 0.
- `rst` asserted mid-update or mid-learning overrides every transition.

Counters
- Widths: `stable_cnt` $clog2(STABLE_CYCLES+1); `learn_cnt` $clog2(LEARN_CYCLES+1); `sweep_cnt` $clog2(MAX_SWEEPS+1).
- No counter wraps except `neuron_idx`.

## Timing
- Input qualification: with `same_input` held at 1 from the first post-reset cycle, UPDATING is entered after exactly STABLE_CYCLES cycles in INPUT.
- Sequential sweep length: NUM_NEURONS cycles. Synchronous sweep length: 1 cycle.
- LEARNING occupies exactly LEARN_CYCLES cycles, then DONE.
- All transitions take effect on the next `clk` rising edge. There are no handshake stalls.

## Configuration
- Macro: HOPFIELD_ITER_LIMIT_EN.
- Defined:
  - at a non-converged sweep end with `sweep_cnt`=MAX_SWEEPS-1, go to FAIL;
  - `timeout`=1 while in FAIL;
  - `same_input`=0 still takes priority over entering FAIL.
- Undefined:
  - no sweep counter is built;
  - FAIL is unreachable;
  - `timeout` is tied 0;
  - UPDATING can run unbounded.

## Structure
- Shared defines file holds the state encodings. Add `STATE_DONE`=3 and `STATE_FAIL`=4 alongside the existing INPUT/UPDATING/LEARNING constants.
- Sub-module `hopfield_sweep_counter` contains:
  - the `neuron_idx` wrap counter;
  - a sweep-end pulse;
  - the `sweep_cnt` (only built under the macro).
  
  Its inputs are `clk`, `rst`, `clear`, `enable` and `mode`.

## Test plan
All scenarios use NUM_NEURONS=4, STABLE_CYCLES=2, LEARN_CYCLES=3, MAX_SWEEPS=5.
- Reset, then `same_input`=1 → `state`=0 for 2 cycles, then `state`=1; `modify_neuron_using_input` falls with the entry to UPDATING.
- Sequential mode, `converged`=1 from cycle 0 of UPDATING, `learn_enable`=1 → `neuron_idx` shows 0,1,2,3; LEARNING follows the idx=3 cycle; `modify_weights` is high for 3 cycles; then `done`=1.
- Synchronous mode, `converged`=1, `learn_enable`=0 → UPDATING lasts 1 cycle, then DONE; `modify_weights` never asserted; `neuron_idx` stays 0.
- `same_input`=0 on the 2nd LEARNING cycle → INPUT next cycle; `modify_weights` drops; `stable_cnt` restarts.
- Macro defined, sequential mode, `converged`=0 → FAIL after 20 UPDATING cycles with `timeout`=1; `same_input`=0 → INPUT. Macro undefined: still in UPDATING after 100 cycles.
- `rst` during cycle 2 of UPDATING → next cycle `state`=0, `neuron_idx`=0, `modify_neuron`=1, `modify_neuron_using_input`=1.

Source files
------------

// File: rtl/hopfield_control_seq_pkg.sv
// Shared state encodings and types for the Hopfield control sequencer.
package hopfield_control_seq_pkg;

    localparam logic [2:0] STATE_INPUT    = 3'd0;
    localparam logic [2:0] STATE_UPDATING = 3'd1;
    localparam logic [2:0] STATE_LEARNING = 3'd2;
    localparam logic [2:0] STATE_DONE     = 3'd3;
    localparam logic [2:0] STATE_FAIL     = 3'd4;

    typedef enum logic [2:0] {
        ST_INPUT    = STATE_INPUT,
        ST_UPDATING = STATE_UPDATING,
        ST_LEARNING = STATE_LEARNING,
        ST_DONE     = STATE_DONE,
        ST_FAIL     = STATE_FAIL
    } state_t;

endpackage

// File: rtl/hopfield_control_seq_if.sv
// Status inputs and datapath strobes between the controller (master) and the Hopfield datapath (slave).
interface hopfield_control_seq_if #(
    parameter int IDX_W = 4
);
    logic             same_input;
    logic             converged;
    logic             update_mode;
    logic             learn_enable;
    logic             modify_neuron;
    logic             modify_neuron_using_input;
    logic             modify_weights;
    logic [IDX_W-1:0] neuron_idx;
    logic             seq_active;
    logic [2:0]       state;
    logic             done;
    logic             timeout;

    modport master (
        input  same_input, converged, update_mode, learn_enable,
        output modify_neuron, modify_neuron_using_input, modify_weights,
               neuron_idx, seq_active, state, done, timeout
    );

    modport slave (
        output same_input, converged, update_mode, learn_enable,
        input  modify_neuron, modify_neuron_using_input, modify_weights,
               neuron_idx, seq_active, state, done, timeout
    );
endinterface

// File: rtl/hopfield_control_seq_sweep_counter.sv
// Neuron index wrap counter and sweep-end pulse; sweep counter only with HOPFIELD_ITER_LIMIT_EN.
module hopfield_sweep_counter #(
    parameter int NUM_NEURONS = 16,
`ifdef HOPFIELD_ITER_LIMIT_EN
    parameter int MAX_SWEEPS  = 32,
`endif
    parameter int IDX_W       = $clog2(NUM_NEURONS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic             mode,
    output logic [IDX_W-1:0] neuron_idx,
    output logic             sweep_end
`ifdef HOPFIELD_ITER_LIMIT_EN
    ,
    output logic             last_sweep
`endif
);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_NEURONS - 1);

    logic [IDX_W-1:0] idx_reg;

    assign neuron_idx = idx_reg;
    // Synchronous mode updates every neuron at once, so each cycle closes a sweep.
    assign sweep_end  = enable && (!mode || idx_reg == IDX_LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            idx_reg <= '0;
        end else if (enable && mode) begin
            idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
        end
    end

`ifdef HOPFIELD_ITER_LIMIT_EN
    localparam int              SW_W    = $clog2(MAX_SWEEPS + 1);
    localparam logic [SW_W-1:0] SW_LAST = SW_W'(MAX_SWEEPS - 1);

    logic [SW_W-1:0] sweep_cnt_reg;

    assign last_sweep = (sweep_cnt_reg == SW_LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sweep_cnt_reg <= '0;
        end else if (sweep_end && sweep_cnt_reg != SW_LAST) begin
            sweep_cnt_reg <= sweep_cnt_reg + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/hopfield_control_seq.sv
// Hopfield network control FSM: input qualification, sync/sequential update, bounded learning, done.
// Optional sweep-limit timeout into FAIL is enabled by defining HOPFIELD_ITER_LIMIT_EN.
module hopfield_control_seq
    import hopfield_control_seq_pkg::*;
#(
    parameter int NUM_NEURONS   = 16,
    parameter int STABLE_CYCLES = 2,
    parameter int LEARN_CYCLES  = 4,
    parameter int MAX_SWEEPS    = 32,
    parameter int IDX_W         = $clog2(NUM_NEURONS)
) (
    input  logic                   clk,
    input  logic                   rst,
    hopfield_control_seq_if.master bus
);
    localparam int              SC_W        = $clog2(STABLE_CYCLES + 1);
    localparam int              LC_W        = $clog2(LEARN_CYCLES + 1);
    localparam logic [SC_W-1:0] STABLE_LAST = SC_W'(STABLE_CYCLES - 1);
    localparam logic [LC_W-1:0] LEARN_LAST  = LC_W'(LEARN_CYCLES - 1);

    state_t           state_reg, state_next;
    logic [SC_W-1:0]  stable_cnt_reg, stable_cnt_next;
    logic [LC_W-1:0]  learn_cnt_reg, learn_cnt_next;
    logic             mode_reg, mode_next;
    logic             sweep_clear;
    logic             sweep_end;
    logic [IDX_W-1:0] idx;
`ifdef HOPFIELD_ITER_LIMIT_EN
    logic             last_sweep;
`endif

    hopfield_sweep_counter #(
        .NUM_NEURONS (NUM_NEURONS),
`ifdef HOPFIELD_ITER_LIMIT_EN
        .MAX_SWEEPS  (MAX_SWEEPS),
`endif
        .IDX_W       (IDX_W)
    ) u_sweep (
        .clk        (clk),
        .rst        (rst),
        .clear      (sweep_clear),
        .enable     (state_reg == ST_UPDATING),
        .mode       (mode_reg),
        .neuron_idx (idx),
        .sweep_end  (sweep_end)
`ifdef HOPFIELD_ITER_LIMIT_EN
        ,
        .last_sweep (last_sweep)
`endif
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_INPUT;
            stable_cnt_reg <= '0;
            learn_cnt_reg  <= '0;
            mode_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            stable_cnt_reg <= stable_cnt_next;
            learn_cnt_reg  <= learn_cnt_next;
            mode_reg       <= mode_next;
        end
    end

    // Counters default to zero so each restarts cleanly whenever its state is re-entered.
    always_comb begin
        state_next      = state_reg;
        stable_cnt_next = '0;
        learn_cnt_next  = '0;
        mode_next       = mode_reg;
        sweep_clear     = 1'b0;
        case (state_reg)
            ST_INPUT: begin
                if (!bus.same_input) begin
                    stable_cnt_next = '0;
                end else if (stable_cnt_reg == STABLE_LAST) begin
                    state_next  = ST_UPDATING;
                    mode_next   = bus.update_mode;
                    sweep_clear = 1'b1;
                end else begin
                    stable_cnt_next = stable_cnt_reg + 1'b1;
                end
            end
            ST_UPDATING: begin
                if (!bus.same_input) begin
                    state_next = ST_INPUT;
                end else if (sweep_end && bus.converged) begin
                    state_next = bus.learn_enable ? ST_LEARNING : ST_DONE;
`ifdef HOPFIELD_ITER_LIMIT_EN
                end else if (sweep_end && last_sweep) begin
                    state_next = ST_FAIL;
`endif
                end
            end
            ST_LEARNING: begin
                if (!bus.same_input) begin
                    state_next = ST_INPUT;
                end else if (learn_cnt_reg == LEARN_LAST) begin
                    state_next = ST_DONE;
                end else begin
                    learn_cnt_next = learn_cnt_reg + 1'b1;
                end
            end
            ST_DONE, ST_FAIL: begin
                if (!bus.same_input) begin
                    state_next = ST_INPUT;
                end
            end
            default: state_next = ST_INPUT;
        endcase
    end

    always_comb begin
        bus.modify_neuron             = (state_reg == ST_INPUT) || (state_reg == ST_UPDATING);
        bus.modify_neuron_using_input = (state_reg == ST_INPUT);
        bus.modify_weights            = (state_reg == ST_LEARNING);
        bus.seq_active                = (state_reg == ST_UPDATING) && mode_reg;
        bus.neuron_idx                = bus.seq_active ? idx : '0;
        bus.state                     = state_reg;
        bus.done                      = (state_reg == ST_DONE);
`ifdef HOPFIELD_ITER_LIMIT_EN
        bus.timeout                   = (state_reg == ST_FAIL);
`else
        bus.timeout                   = 1'b0;
`endif
    end

endmodule

// File: tb/tb_hopfield_control_seq.sv
// Self-checking bench for hopfield_control_seq: directed scenarios plus randomized run against a behavioural model.
module tb_hopfield_control_seq;
    localparam int N  = 4;
    localparam int S  = 2;
    localparam int L  = 3;
    localparam int M  = 5;
`ifdef HOPFIELD_ITER_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    hopfield_control_seq_if #(.IDX_W(2)) bus ();

    hopfield_control_seq #(
        .NUM_NEURONS   (N),
        .STABLE_CYCLES (S),
        .LEARN_CYCLES  (L),
        .MAX_SWEEPS    (M),
        .IDX_W         (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: phase number plus plain integer progress counters.
    int m_state, m_stable, m_pos, m_sweeps, m_learn;
    bit m_mode;

    function automatic void model_step(input bit r, input bit si, input bit cv,
                                       input bit um, input bit le);
        bit at_end;
        if (r) begin
            m_state = 0; m_stable = 0; m_pos = 0; m_sweeps = 0; m_learn = 0; m_mode = 0;
            return;
        end
        case (m_state)
            0: begin
                if (!si) m_stable = 0;
                else if (m_stable + 1 >= S) begin
                    m_state = 1; m_mode = um; m_pos = 0; m_sweeps = 0; m_stable = 0;
                end else m_stable++;
            end
            1: begin
                at_end = m_mode ? (m_pos == N - 1) : 1'b1;
                if (!si) m_state = 0;
                else if (at_end && cv) begin
                    m_state = le ? 2 : 3; m_learn = 0;
                end else if (at_end && LIMIT_EN && m_sweeps + 1 >= M) m_state = 4;
                else if (at_end) m_sweeps++;
                if (m_mode) m_pos = (m_pos + 1) % N;
            end
            2: begin
                if (!si) m_state = 0;
                else if (m_learn + 1 >= L) m_state = 3;
                else m_learn++;
            end
            default: if (!si) m_state = 0;
        endcase
        if (m_state != 2) m_learn = 0;
        if (m_state != 0) m_stable = 0;
    endfunction

    task automatic cycle(input bit r, input bit si, input bit cv, input bit um, input bit le);
        rst = r;
        bus.same_input = si;
        bus.converged = cv;
        bus.update_mode = um;
        bus.learn_enable = le;
        @(posedge clk);
        model_step(r, si, cv, um, le);
        #1;
    endtask

    task automatic test_reset();
        cycle(1, 1, 0, 0, 0);
        checks++;
        if (bus.state !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", bus.state); end
        checks++;
        if (bus.modify_neuron !== 1'b1 || bus.modify_neuron_using_input !== 1'b1) begin
            errors++; $display("FAIL reset_mn got=%b%b exp=11", bus.modify_neuron, bus.modify_neuron_using_input);
        end
        checks++;
        if ({bus.modify_weights, bus.neuron_idx, bus.seq_active, bus.done, bus.timeout} !== 6'b0) begin
            errors++; $display("FAIL reset_others got=%b exp=000000",
                {bus.modify_weights, bus.neuron_idx, bus.seq_active, bus.done, bus.timeout});
        end
        cycle(0, 1, 0, 0, 0);
        checks++;
        if (bus.state !== 3'd0) begin errors++; $display("FAIL qual_hold got=%0d exp=0", bus.state); end
        cycle(0, 1, 0, 0, 0);
        checks++;
        if (bus.state !== 3'd1 || bus.modify_neuron_using_input !== 1'b0) begin
            errors++; $display("FAIL qual_enter got state=%0d mnui=%b exp state=1 mnui=0",
                bus.state, bus.modify_neuron_using_input);
        end
        $display("test_reset done");
    endtask

    task automatic test_seq_learn();
        cycle(1, 1, 1, 1, 1);
        cycle(0, 1, 1, 1, 1);
        for (int k = 0; k < N; k++) begin
            cycle(0, 1, 1, 1, 1);
            checks++;
            if (bus.state !== 3'd1 || bus.neuron_idx !== 2'(k) || bus.seq_active !== 1'b1) begin
                errors++; $display("FAIL seq_idx got state=%0d idx=%0d sa=%b exp state=1 idx=%0d sa=1",
                    bus.state, bus.neuron_idx, bus.seq_active, k);
            end
        end
        for (int k = 0; k < L; k++) begin
            cycle(0, 1, 1, 1, 1);
            checks++;
            if (bus.state !== 3'd2 || bus.modify_weights !== 1'b1 || bus.modify_neuron !== 1'b0) begin
                errors++; $display("FAIL seq_learn got state=%0d mw=%b mn=%b exp state=2 mw=1 mn=0",
                    bus.state, bus.modify_weights, bus.modify_neuron);
            end
        end
        cycle(0, 1, 1, 1, 1);
        checks++;
        if (bus.state !== 3'd3 || bus.done !== 1'b1 || bus.modify_weights !== 1'b0) begin
            errors++; $display("FAIL seq_done got state=%0d done=%b mw=%b exp state=3 done=1 mw=0",
                bus.state, bus.done, bus.modify_weights);
        end
        $display("test_seq_learn done");
    endtask

    task automatic test_sync_done();
        cycle(1, 1, 1, 0, 0);
        cycle(0, 1, 1, 0, 0);
        cycle(0, 1, 1, 0, 0);
        checks++;
        if (bus.state !== 3'd1 || bus.neuron_idx !== 2'd0 || bus.seq_active !== 1'b0) begin
            errors++; $display("FAIL sync_upd got state=%0d idx=%0d sa=%b exp state=1 idx=0 sa=0",
                bus.state, bus.neuron_idx, bus.seq_active);
        end
        for (int k = 0; k < 2; k++) begin
            cycle(0, 1, 1, 0, 0);
            checks++;
            if (bus.state !== 3'd3 || bus.done !== 1'b1 || bus.modify_weights !== 1'b0 || bus.neuron_idx !== 2'd0) begin
                errors++; $display("FAIL sync_done got state=%0d done=%b mw=%b idx=%0d exp state=3 done=1 mw=0 idx=0",
                    bus.state, bus.done, bus.modify_weights, bus.neuron_idx);
            end
        end
        $display("test_sync_done done");
    endtask

    task automatic test_abort_learning();
        cycle(1, 1, 1, 0, 1);
        cycle(0, 1, 1, 0, 1);
        cycle(0, 1, 1, 0, 1);
        cycle(0, 1, 1, 0, 1);
        cycle(0, 1, 1, 0, 1);
        checks++;
        if (bus.state !== 3'd2) begin errors++; $display("FAIL abort_pre got=%0d exp=2", bus.state); end
        cycle(0, 0, 1, 0, 1);
        checks++;
        if (bus.state !== 3'd0 || bus.modify_weights !== 1'b0) begin
            errors++; $display("FAIL abort_input got state=%0d mw=%b exp state=0 mw=0", bus.state, bus.modify_weights);
        end
        cycle(0, 1, 1, 0, 1);
        checks++;
        if (bus.state !== 3'd0) begin errors++; $display("FAIL abort_restart got=%0d exp=0", bus.state); end
        cycle(0, 1, 1, 0, 1);
        checks++;
        if (bus.state !== 3'd1) begin errors++; $display("FAIL abort_requal got=%0d exp=1", bus.state); end
        $display("test_abort_learning done");
    endtask

    task automatic test_timeout();
        int upd;
        cycle(1, 1, 0, 1, 0);
        cycle(0, 1, 0, 1, 0);
        cycle(0, 1, 0, 1, 0);
        upd = (bus.state === 3'd1) ? 1 : 0;
        for (int k = 0; k < 120; k++) begin
            cycle(0, 1, 0, 1, 0);
            if (bus.state !== 3'd1) break;
            upd++;
        end
        if (LIMIT_EN) begin
            checks++;
            if (upd != N * M || bus.state !== 3'd4 || bus.timeout !== 1'b1) begin
                errors++; $display("FAIL timeout_enter got upd=%0d state=%0d to=%b exp upd=%0d state=4 to=1",
                    upd, bus.state, bus.timeout, N * M);
            end
            cycle(0, 0, 0, 1, 0);
            checks++;
            if (bus.state !== 3'd0 || bus.timeout !== 1'b0) begin
                errors++; $display("FAIL timeout_exit got state=%0d to=%b exp state=0 to=0", bus.state, bus.timeout);
            end
        end else begin
            checks++;
            if (upd < 100 || bus.state !== 3'd1 || bus.timeout !== 1'b0) begin
                errors++; $display("FAIL unbounded got upd=%0d state=%0d to=%b exp upd>=100 state=1 to=0",
                    upd, bus.state, bus.timeout);
            end
        end
        $display("test_timeout done");
    endtask

    task automatic test_rst_mid();
        cycle(1, 1, 0, 1, 0);
        cycle(0, 1, 0, 1, 0);
        cycle(0, 1, 0, 1, 0);
        cycle(0, 1, 0, 1, 0);
        checks++;
        if (bus.state !== 3'd1 || bus.neuron_idx !== 2'd1) begin
            errors++; $display("FAIL rst_pre got state=%0d idx=%0d exp state=1 idx=1", bus.state, bus.neuron_idx);
        end
        cycle(1, 1, 0, 1, 0);
        checks++;
        if (bus.state !== 3'd0 || bus.neuron_idx !== 2'd0 || bus.modify_neuron !== 1'b1 ||
            bus.modify_neuron_using_input !== 1'b1 || bus.seq_active !== 1'b0) begin
            errors++; $display("FAIL rst_mid got state=%0d idx=%0d mn=%b mnui=%b sa=%b exp 0 0 1 1 0",
                bus.state, bus.neuron_idx, bus.modify_neuron, bus.modify_neuron_using_input, bus.seq_active);
        end
        $display("test_rst_mid done");
    endtask

    task automatic test_random();
        logic [10:0] got, exp;
        cycle(1, 1, 0, 0, 0);
        for (int k = 0; k < 600; k++) begin
            cycle($urandom_range(0, 149) == 0, $urandom_range(0, 11) != 0, $urandom_range(0, 3) == 0,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            exp = {3'(m_state),
                   m_state == 0 || m_state == 1,
                   m_state == 0,
                   m_state == 2,
                   (m_state == 1 && m_mode) ? 2'(m_pos) : 2'd0,
                   m_state == 1 && m_mode,
                   m_state == 3,
                   m_state == 4};
            got = {bus.state, bus.modify_neuron, bus.modify_neuron_using_input, bus.modify_weights,
                   bus.neuron_idx, bus.seq_active, bus.done, bus.timeout};
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL random_cycle%0d got=%b exp=%b", k, got, exp);
            end
        end
        $display("test_random done");
    endtask

    initial begin
        bus.same_input = 1'b0;
        bus.converged = 1'b0;
        bus.update_mode = 1'b0;
        bus.learn_enable = 1'b0;
        test_reset();
        test_seq_learn();
        test_sync_done();
        test_abort_learning();
        test_timeout();
        test_rst_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
